uart_tx_feeder: RTL and testbench

Byte buffer and sequencer that sits directly upstream of the UART transmitter. It accepts bytes from a producer over a valid/ready handshake and stores them in a circular FIFO. It hands the bytes to the transmitter one at a time, using the transmitter's tx_start / tx_data / tx_done protocol. It decouples software or bus-side bursts from the serial line rate.

---
 rtl/uart_tx_feeder.sv | 119 +++++++++++
 tb/tb_uart_tx_feeder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus a three-state sequencer that feeds a UART transmitter.
// Producer side is a valid/ready handshake. Transmitter side is a
// tx_start pulse, a registered tx_data byte and a tx_done acknowledge.
module uart_tx_feeder #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 tx_start,
  output logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_done,
  output logic [ADDR_W:0]      count,
  output logic                 busy
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]      count_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic full, empty, push, pop;

  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign in_ready = !full && !flush && !rst;
  assign push     = in_valid && in_ready;

  // Next-state logic; pop is asserted only when the FSM launches a new byte.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !flush) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        if (tx_done) begin
          if (!empty && !flush) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state, output byte register, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        tx_data_q <= mem_q[rd_ptr_q];
      end
      // Flush wipes the queue but leaves the in-flight byte and FSM alone.
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        end
        if (push && !pop) begin
          count_q <= count_q + (ADDR_W + 1)'(1);
        end else if (pop && !push) begin
          count_q <= count_q - (ADDR_W + 1)'(1);
        end
      end
    end
  end

  // Storage array; no reset needed since only written slots are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign tx_start = (state_q == StStart);
  assign busy     = (state_q != StIdle);
  assign tx_data  = tx_data_q;
  assign count    = count_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_feeder;

  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;

  typedef logic [7:0] byte_q_t [$];

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [DATA_BITS-1:0] in_data = '0;
  logic                 in_ready;
  logic                 flush = 1'b0;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_done = 1'b0;
  logic [ADDR_W:0]      count;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_feeder #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .flush   (flush),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .count   (count),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored bytes, whether a byte is in flight,
  // whether this is its start cycle, and the byte last handed out.
  logic [7:0] mq [$];
  logic       m_flight = 1'b0;
  logic       m_start  = 1'b0;
  logic [7:0] m_data   = '0;
  logic       m_valid  = 1'b0;
  logic       m_acc, m_can_pop, m_do_pop;
  byte_q_t    tx_log;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_acc = in_valid && (mq.size() < DEPTH) && !flush && !rst;
    if (rst) begin
      mq.delete();
      m_flight = 1'b0;
      m_start  = 1'b0;
      m_data   = '0;
    end else begin
      m_can_pop = (mq.size() != 0) && !flush;
      m_do_pop  = 1'b0;
      if (!m_flight) begin
        if (m_can_pop) begin
          m_do_pop = 1'b1;
          m_flight = 1'b1;
          m_start  = 1'b1;
        end
      end else if (m_start) begin
        m_start = 1'b0;
      end else if (tx_done) begin
        if (m_can_pop) begin
          m_do_pop = 1'b1;
          m_start  = 1'b1;
        end else begin
          m_flight = 1'b0;
        end
      end
      if (m_do_pop) m_data = mq.pop_front();
      if (flush) mq.delete();
      else if (m_acc) mq.push_back(in_data);
    end
    m_valid = 1'b1;
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      cmp("model_tx_start", 32'(tx_start), 32'(m_start));
      cmp("model_tx_data", 32'(tx_data), 32'(m_data));
      cmp("model_busy", 32'(busy), 32'(m_flight));
      cmp("model_count", 32'(count), 32'(mq.size()));
      cmp("model_in_ready", 32'(in_ready), 32'((mq.size() != DEPTH) && !flush && !rst));
      if (tx_start === 1'b1) tx_log.push_back(tx_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Tick once; drop in_valid if the byte on offer was taken at that edge.
  task automatic tick_acc();
    logic acc;
    acc = in_valid && in_ready;
    tick(1);
    if (acc) in_valid = 1'b0;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = first + 8'(i);
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for the transmitter-wait phase, then pulse tx_done once.
  task automatic pulse_done();
    int n;
    n = 0;
    while (!(busy === 1'b1 && tx_start === 1'b0) && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout: busy=%0b tx_start=%0b never reached wait phase", busy, tx_start);
    end else begin
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
    end
  endtask

  task automatic check_log(input string name, input byte_q_t exp);
    cmp({name, "_len"}, 32'(tx_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < tx_log.size(); i++) begin
      cmp(name, 32'(tx_log[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    byte_q_t exp_log;

    // Reset state.
    tick(2);
    cmp("rst_in_ready", 32'(in_ready), 32'd0);
    cmp("rst_count", 32'(count), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_tx_start", 32'(tx_start), 32'd0);
    cmp("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    #1;
    cmp("rel_in_ready", 32'(in_ready), 32'd1);

    // Basic send of 0xA5.
    tx_log.delete();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick(1);
    in_valid = 1'b0;
    cmp("basic_count_k", 32'(count), 32'd1);
    cmp("basic_start_k", 32'(tx_start), 32'd0);
    tick(1);
    cmp("basic_start_k1", 32'(tx_start), 32'd1);
    cmp("basic_data", 32'(tx_data), 32'hA5);
    cmp("basic_busy", 32'(busy), 32'd1);
    cmp("basic_count0", 32'(count), 32'd0);
    tick(1);
    cmp("basic_start_k2", 32'(tx_start), 32'd0);
    cmp("basic_busy_wait", 32'(busy), 32'd1);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    cmp("basic_idle", 32'(busy), 32'd0);
    exp_log = '{8'hA5};
    check_log("basic_log", exp_log);

    // Fill and drain with tx_done held low.
    tx_log.delete();
    push_bytes(8'h00, 17);
    cmp("fill_count", 32'(count), 32'd16);
    cmp("fill_in_ready", 32'(in_ready), 32'd0);
    cmp("fill_inflight", 32'(tx_data), 32'h00);
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick(2);
    cmp("fill_stall", 32'(count), 32'd16);
    for (int p = 0; p < 17; p++) begin
      cmp("drain_wait", 32'(busy && !tx_start), 32'd1);
      tx_done = 1'b1;
      tick_acc();
      tx_done = 1'b0;
      cmp("drain_start_after_done", 32'(tx_start), 32'd1);
      tick_acc();
    end
    cmp("drain_late_taken", 32'(in_valid), 32'd0);
    pulse_done();
    cmp("drain_idle", 32'(busy), 32'd0);
    exp_log.delete();
    for (int i = 0; i <= 8'h11; i++) exp_log.push_back(8'(i));
    check_log("drain_log", exp_log);

    // Push and pop on the same edge.
    tx_log.delete();
    push_bytes(8'h41, 4);
    cmp("conc_count_pre", 32'(count), 32'd3);
    tx_done  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5C;
    tick(1);
    tx_done  = 1'b0;
    in_valid = 1'b0;
    cmp("conc_count", 32'(count), 32'd3);
    cmp("conc_start", 32'(tx_start), 32'd1);
    cmp("conc_data", 32'(tx_data), 32'h42);
    repeat (4) pulse_done();
    cmp("conc_idle", 32'(busy), 32'd0);
    exp_log = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h5C};
    check_log("conc_log", exp_log);

    // Flush while waiting with five bytes queued.
    tx_log.delete();
    push_bytes(8'h60, 6);
    cmp("flush_count_pre", 32'(count), 32'd5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    #1;
    cmp("flush_in_ready", 32'(in_ready), 32'd0);
    tick(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    cmp("flush_count", 32'(count), 32'd0);
    cmp("flush_data", 32'(tx_data), 32'h60);
    cmp("flush_busy", 32'(busy), 32'd1);
    pulse_done();
    cmp("flush_idle", 32'(busy), 32'd0);
    tick(3);
    cmp("flush_no_push", 32'(count), 32'd0);
    exp_log = '{8'h60};
    check_log("flush_log", exp_log);

    // Reset while waiting with four bytes queued.
    push_bytes(8'h80, 5);
    cmp("rst2_count_pre", 32'(count), 32'd4);
    rst = 1'b1;
    tick(1);
    cmp("rst2_count", 32'(count), 32'd0);
    cmp("rst2_busy", 32'(busy), 32'd0);
    cmp("rst2_tx_start", 32'(tx_start), 32'd0);
    cmp("rst2_tx_data", 32'(tx_data), 32'd0);
    cmp("rst2_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    cmp("rst2_in_ready_rel", 32'(in_ready), 32'd1);
    tx_log.delete();
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    tick(3);
    cmp("rst2_no_start", 32'(tx_log.size()), 32'd0);

    // Spurious tx_done in idle, then a single byte.
    tx_done = 1'b1;
    tick(2);
    tx_done = 1'b0;
    cmp("spur_busy", 32'(busy), 32'd0);
    cmp("spur_count", 32'(count), 32'd0);
    push_bytes(8'h3C, 1);
    tick(5);
    cmp("spur_data", 32'(tx_data), 32'h3C);
    exp_log = '{8'h3C};
    check_log("spur_log", exp_log);
    pulse_done();
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
